// File: rtl/trap_controller_if.sv
// Signal bundle between the trap sequencer and the surrounding core/CSR logic.
// The slave modport is the trap controller's view; the master modport is the
// core/CSR side that drives retire information and consumes the strobes.
interface trap_controller_if;
  // Core / CSR unit -> trap controller
  logic        irqPending;
  logic        instrRetire;
  logic [31:0] retirePc;
  logic        isMret;
  logic [31:0] mepcValue;

  // Trap controller -> core / CSR unit
  logic        csrWriteEnable;
  logic [31:0] pcFromCore;
  logic        pcRedirect;
  logic [31:0] pcRedirectTarget;
  logic        stallCore;
  logic        irqAck;
  logic        inHandler;

  modport slave (
    input  irqPending,
    input  instrRetire,
    input  retirePc,
    input  isMret,
    input  mepcValue,
    output csrWriteEnable,
    output pcFromCore,
    output pcRedirect,
    output pcRedirectTarget,
    output stallCore,
    output irqAck,
    output inHandler
  );

  modport master (
    output irqPending,
    output instrRetire,
    output retirePc,
    output isMret,
    output mepcValue,
    input  csrWriteEnable,
    input  pcFromCore,
    input  pcRedirect,
    input  pcRedirectTarget,
    input  stallCore,
    input  irqAck,
    input  inHandler
  );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer. Takes a level interrupt at an instruction
// boundary, strobes the resume PC into mepc, redirects fetch to the trap
// vector, and on mret redirects fetch to whatever mepc holds at return time
// (so a software task switch through the CSR bus is honoured).
module trap_controller #(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic           clock,
  input  logic           resetActiveLow,
  trap_controller_if.slave bus
);

  localparam logic [2:0] RUN     = 3'd0;
  localparam logic [2:0] SAVE    = 3'd1;
  localparam logic [2:0] VECTOR  = 3'd2;
  localparam logic [2:0] HANDLER = 3'd3;
  localparam logic [2:0] RETURN  = 3'd4;

  logic [2:0]  state;
  logic [2:0]  nextState;
  logic [31:0] savedPc;

  // Next-state selection; retire inputs only matter in RUN and HANDLER.
  always_comb begin
    // NOTE: default first so every path assigns nextState and no latch is inferred.
    nextState = state;
    case (state)
      RUN: begin
        if (bus.instrRetire && bus.isMret)
          nextState = RETURN;
        else if (bus.instrRetire && bus.irqPending)
          nextState = SAVE;
      end
      SAVE:    nextState = VECTOR;
      VECTOR:  nextState = HANDLER;
      HANDLER: begin
        if (bus.instrRetire && bus.isMret)
          nextState = RETURN;
      end
      RETURN:  nextState = RUN;
      default: nextState = RUN;
    endcase
  end

  // State register and resume-PC capture on interrupt acceptance.
  always_ff @(posedge clock or negedge resetActiveLow) begin
    if (!resetActiveLow) begin
      state   <= RUN;
      savedPc <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state <= nextState;
      if (state == RUN && bus.instrRetire && bus.irqPending && !bus.isMret)
        savedPc <= bus.retirePc;
    end
  end

  // Moore output decode; the return target alone follows mepcValue live.
  always_comb begin
    bus.csrWriteEnable   = 1'b0;
    bus.pcFromCore       = savedPc;
    bus.pcRedirect       = 1'b0;
    bus.pcRedirectTarget = '0;
    bus.stallCore        = 1'b0;
    bus.irqAck           = 1'b0;
    bus.inHandler        = 1'b0;
    case (state)
      SAVE: begin
        bus.csrWriteEnable = 1'b1;
        bus.irqAck         = 1'b1;
        bus.stallCore      = 1'b1;
      end
      VECTOR: begin
        bus.pcRedirect       = 1'b1;
        bus.pcRedirectTarget = TRAP_VECTOR;
        bus.stallCore        = 1'b1;
      end
      HANDLER: begin
        bus.inHandler = 1'b1;
      end
      RETURN: begin
        bus.pcRedirect       = 1'b1;
        bus.pcRedirectTarget = bus.mepcValue;
        bus.stallCore        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
